score_bcd_display: RTL

- Downstream consumer of the 16-bit binary game score produced by the score counter.
- On each game_tick frame pulse, converts the score to packed BCD using a sequential shift-add-3 (double-dabble) engine.
- Holds the converted digits and drives a time-multiplexed 7-segment display.
- Optionally tracks a high score captured at game_over.

---
 rtl/score_bcd_display.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/score_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : score_bcd_display
// Description : Binary score to BCD (double-dabble) with a multiplexed 7-seg scan.
//               Optional high-score tracking is enabled by defining SCORE_HISCORE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_display #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      score,
    input  logic                  game_tick,
    input  logic                  game_over,
    input  logic                  show_hi,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [WIDTH-1:0]      hi_score
);

    localparam int c_cnt_w  = $clog2(WIDTH + 1);
    localparam int c_scan_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_cnt_w-1:0]  c_last_iter = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_scan_w-1:0] c_scan_one  = c_scan_w'(1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0]  c_idx_one   = c_idx_w'(1);
    localparam logic [DIGITS-1:0]   c_sel_reset = DIGITS'(1);
    localparam logic [6:0]          c_seg_zero  = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH-1:0]      r_bin;
    logic [4*DIGITS-1:0]   r_work;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_pend;
    logic [WIDTH-1:0]      r_pend_val;
    logic [4*DIGITS-1:0]   r_bcd;

    logic                  w_pend_next;
    logic [WIDTH-1:0]      w_pend_val_next;
    logic                  w_start;
    logic [WIDTH-1:0]      w_start_val;
    logic                  w_last_iter;
    logic [WIDTH-1:0]      w_src;
    logic [4*DIGITS-1:0]   w_work_adj;
    logic [4*DIGITS-1:0]   w_work_shift;
    logic                  w_unused;

`ifdef SCORE_HISCORE_EN
    logic [WIDTH-1:0]      r_hi_score;

    // The tick samples the pre-update high score, so a same-cycle game_over is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_score <= '0;
        end else if (game_over && (score > r_hi_score)) begin
            r_hi_score <= score;
        end
    end

    assign hi_score = r_hi_score;
    assign w_src    = show_hi ? r_hi_score : score;
    assign w_unused = w_work_adj[4*DIGITS-1];
`else
    assign hi_score = '0;
    assign w_src    = score;
    assign w_unused = ^{w_work_adj[4*DIGITS-1], game_over, show_hi};
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_work_adj[4*g +: 4] = (r_work[4*g +: 4] >= 4'd5) ?
                                      (r_work[4*g +: 4] + 4'd3) : r_work[4*g +: 4];
    end

    assign w_work_shift = {w_work_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
    assign w_last_iter  = (r_cnt == c_last_iter);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_start         = 1'b0;
        w_start_val     = w_src;
        w_pend_next     = r_pend;
        w_pend_val_next = r_pend_val;
        case (r_state)
            S_IDLE: begin
                // A tick left pending by the DONE cycle is started from here.
                if (game_tick || r_pend) begin
                    w_start      = 1'b1;
                    w_start_val  = game_tick ? w_src : r_pend_val;
                    w_pend_next  = 1'b0;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (game_tick) begin
                    w_pend_next     = 1'b1;
                    w_pend_val_next = w_src;
                end
                if (w_last_iter) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (r_pend) begin
                    w_start      = 1'b1;
                    w_start_val  = r_pend_val;
                    w_pend_next  = 1'b0;
                    w_state_next = S_CONV;
                end else begin
                    w_state_next = S_IDLE;
                end
                if (game_tick) begin
                    w_pend_next     = 1'b1;
                    w_pend_val_next = w_src;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin      <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_bcd      <= '0;
        end else begin
            r_pend     <= w_pend_next;
            r_pend_val <= w_pend_val_next;
            if (w_start) begin
                r_bin  <= w_start_val;
                r_work <= '0;
                r_cnt  <= '0;
            end else if (r_state == S_CONV) begin
                r_bin  <= {r_bin[WIDTH-2:0], 1'b0};
                r_work <= w_work_shift;
                r_cnt  <= r_cnt + c_cnt_one;
            end
            // Commit on the final shift so bcd is already new during the DONE cycle.
            if ((r_state == S_CONV) && w_last_iter) begin
                r_bcd <= w_work_shift;
            end
        end
    end

    assign bcd       = r_bcd;
    assign bcd_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_CONV);

    logic [c_scan_w-1:0] r_scan_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [DIGITS-1:0]   r_digit_sel;
    logic [6:0]          r_seg;
    logic                w_scan_wrap;
    logic [c_idx_w-1:0]  w_idx_next;
    logic [DIGITS-1:0]   w_sel_next;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg_next;

    assign w_scan_wrap = (r_scan_cnt == c_scan_last);

    always_comb begin
        w_idx_next = r_idx;
        if (w_scan_wrap) begin
            w_idx_next = (r_idx == c_idx_last) ? '0 : (r_idx + c_idx_one);
        end
    end

    always_comb begin
        w_sel_next = '0;
        w_nib      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_next == c_idx_w'(i)) begin
                w_sel_next[i] = 1'b1;
                w_nib         = r_bcd[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_seg_next = 7'h00;
        case (w_nib)
            4'd0:    w_seg_next = 7'h3F;
            4'd1:    w_seg_next = 7'h06;
            4'd2:    w_seg_next = 7'h5B;
            4'd3:    w_seg_next = 7'h4F;
            4'd4:    w_seg_next = 7'h66;
            4'd5:    w_seg_next = 7'h6D;
            4'd6:    w_seg_next = 7'h7D;
            4'd7:    w_seg_next = 7'h07;
            4'd8:    w_seg_next = 7'h7F;
            4'd9:    w_seg_next = 7'h6F;
            default: w_seg_next = 7'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_idx       <= '0;
            r_digit_sel <= c_sel_reset;
            r_seg       <= c_seg_zero;
        end else begin
            r_scan_cnt  <= w_scan_wrap ? '0 : (r_scan_cnt + c_scan_one);
            r_idx       <= w_idx_next;
            r_digit_sel <= w_sel_next;
            r_seg       <= w_seg_next;
        end
    end

    assign digit_sel = r_digit_sel;
    assign seg       = r_seg;

endmodule
`default_nettype wire
